// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
package arbitro_pkg;

    typedef enum logic {
        OCIOSO    = 1'b0,
        CONCEDIDO = 1'b1
    } estado_t;

    function automatic int unsigned num_req(input int unsigned num_bits);
        return 32'(1) << num_bits;
    endfunction

endpackage

// File: rtl/arbitro_rr_onehot_seletor_rr.sv
// Combinational round-robin selector: first set request at or above ponteiro, wrapping.
module seletor_rr
    import arbitro_pkg::*;
#(
    parameter int unsigned NUM_BITS = 4
) (
    input  logic [num_req(NUM_BITS)-1:0] req,
    input  logic [NUM_BITS-1:0]          ponteiro,
    output logic [NUM_BITS-1:0]          indice,
    output logic                         encontrado
);

    localparam int unsigned N = num_req(NUM_BITS);

    logic [2*N-1:0]      req_duplo;
    logic [2*N-1:0]      req_deslocado;
    logic [N-1:0]        req_rodado;
    logic [NUM_BITS-1:0] posicao;

    // Doubling the vector turns the rotate-right into a plain shift.
    assign req_duplo     = {req, req};
    assign req_deslocado = req_duplo >> ponteiro;
    assign req_rodado    = req_deslocado[N-1:0];

    always_comb begin
        posicao = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rodado[i]) begin
                posicao = NUM_BITS'(i);
            end
        end
    end

    assign indice     = posicao + ponteiro;
    assign encontrado = |req;

endmodule

// File: rtl/arbitro_rr_onehot.sv
// Round-robin arbiter with hold-until-release grant, timeout and binary/one-hot grant outputs.
module arbitro_rr_onehot
    import arbitro_pkg::*;
#(
    parameter int unsigned NUM_BITS  = 4,
    parameter int unsigned MAX_POSSE = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [num_req(NUM_BITS)-1:0] req,
    input  logic                         liberar,
    output logic                         grant_valido,
    output logic [NUM_BITS-1:0]          grant_indice,
    output logic [num_req(NUM_BITS)-1:0] grant_vetor,
    output logic                         timeout_pulso
);

    localparam int unsigned N      = num_req(NUM_BITS);
    localparam int unsigned CW     = (MAX_POSSE == 0) ? 1 : $clog2(MAX_POSSE + 1);
    localparam int unsigned LIMITE = (MAX_POSSE == 0) ? 0 : MAX_POSSE - 1;

    estado_t             estado, estado_n;
    logic [NUM_BITS-1:0] ponteiro, ponteiro_n;
    logic [NUM_BITS-1:0] indice_n;
    logic [CW-1:0]       contador, contador_n;
    logic                timeout_n;

    logic [NUM_BITS-1:0] sel_indice;
    logic                sel_encontrado;
    logic                req_ativo;
    logic                fim_posse;

    seletor_rr #(
        .NUM_BITS(NUM_BITS)
    ) u_seletor (
        .req       (req),
        .ponteiro  (ponteiro),
        .indice    (sel_indice),
        .encontrado(sel_encontrado)
    );

    assign req_ativo = req[grant_indice];
    assign fim_posse = (MAX_POSSE != 0) && (contador == CW'(LIMITE));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            estado        <= OCIOSO;
            ponteiro      <= '0;
            grant_indice  <= '0;
            contador      <= '0;
            timeout_pulso <= 1'b0;
        end else begin
            estado        <= estado_n;
            ponteiro      <= ponteiro_n;
            grant_indice  <= indice_n;
            contador      <= contador_n;
            timeout_pulso <= timeout_n;
        end
    end

    // Next-state logic
    always_comb begin
        estado_n   = estado;
        ponteiro_n = ponteiro;
        indice_n   = grant_indice;
        contador_n = contador;
        timeout_n  = 1'b0;

        case (estado)
            OCIOSO: begin
                if (sel_encontrado) begin
                    indice_n   = sel_indice;
                    contador_n = '0;
                    estado_n   = CONCEDIDO;
                end
            end
            CONCEDIDO: begin
                if (contador != '1) begin
                    contador_n = contador + CW'(1);
                end
                if (liberar || !req_ativo || fim_posse) begin
                    estado_n   = OCIOSO;
                    ponteiro_n = grant_indice + NUM_BITS'(1);
                    // Pulse only when nothing but the timeout ended the grant.
                    timeout_n  = !liberar && req_ativo;
                end
            end
            default: estado_n = OCIOSO;
        endcase
    end

    assign grant_valido = (estado == CONCEDIDO);
    assign grant_vetor  = grant_valido ? (N'(1) << grant_indice) : '0;

endmodule

// File: tb/tb_arbitro_rr_onehot.sv
// Directed self-checking bench for arbitro_rr_onehot (NUM_BITS=4, MAX_POSSE=8).
module tb_arbitro_rr_onehot;

    localparam int unsigned NUM_BITS  = 4;
    localparam int unsigned MAX_POSSE = 8;
    localparam int unsigned N         = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req;
    logic                liberar;
    logic                grant_valido;
    logic [NUM_BITS-1:0] grant_indice;
    logic [N-1:0]        grant_vetor;
    logic                timeout_pulso;

    int checks   = 0;
    int failures = 0;

    arbitro_rr_onehot #(
        .NUM_BITS (NUM_BITS),
        .MAX_POSSE(MAX_POSSE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .liberar      (liberar),
        .grant_valido (grant_valido),
        .grant_indice (grant_indice),
        .grant_vetor  (grant_vetor),
        .timeout_pulso(timeout_pulso)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    // One clock, then sample just after the edge and check the one-hot invariant.
    task automatic passo();
        @(posedge clk);
        #1;
        verifica("onehot_inv", 32'({$onehot0(grant_vetor), (grant_vetor != '0)}),
                 32'({1'b1, grant_valido}));
    endtask

    task automatic confere_grant(input string tag, input logic [NUM_BITS-1:0] idx);
        logic [N-1:0] um;
        um = N'(1);
        verifica({tag, "_valido"}, 32'(grant_valido), 32'd1);
        verifica({tag, "_indice"}, 32'(grant_indice), 32'(idx));
        verifica({tag, "_vetor"},  32'(grant_vetor),  32'(um << idx));
    endtask

    task automatic solta(input string tag, input logic [NUM_BITS-1:0] ptr_esp);
        liberar = 1'b1;
        passo();
        liberar = 1'b0;
        verifica({tag, "_rel_valido"}, 32'(grant_valido), 32'd0);
        verifica({tag, "_rel_vetor"},  32'(grant_vetor),  32'd0);
        verifica({tag, "_rel_tmo"},    32'(timeout_pulso), 32'd0);
        verifica({tag, "_ponteiro"},   32'(dut.ponteiro), 32'(ptr_esp));
    endtask

    initial begin
        logic [NUM_BITS-1:0] ordem [5];
        ordem = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd0};

        rst     = 1'b1;
        req     = '0;
        liberar = 1'b0;
        passo();
        passo();
        verifica("rst_valido",   32'(grant_valido),  32'd0);
        verifica("rst_indice",   32'(grant_indice),  32'd0);
        verifica("rst_vetor",    32'(grant_vetor),   32'd0);
        verifica("rst_tmo",      32'(timeout_pulso), 32'd0);
        verifica("rst_ponteiro", 32'(dut.ponteiro),  32'd0);
        rst = 1'b0;

        // Single request
        req = 16'h0010;
        passo();
        confere_grant("single", 4'd4);
        req = '0;
        solta("single", 4'd5);
        passo();
        verifica("idle_valido", 32'(grant_valido), 32'd0);

        // Fairness from pointer 0
        rst = 1'b1;
        passo();
        rst = 1'b0;
        req = 16'h8421;
        for (int i = 0; i < 5; i++) begin
            passo();
            confere_grant("rr", ordem[i]);
            solta("rr", ordem[i] + 4'd1);
        end
        req = '0;

        // Wrap-around
        req = 16'h4000;
        passo();
        confere_grant("wrap14", 4'd14);
        req = '0;
        solta("wrap14", 4'd15);
        req = 16'h0003;
        passo();
        confere_grant("wrap0", 4'd0);
        solta("wrap0", 4'd1);
        passo();
        confere_grant("wrap1", 4'd1);
        req = '0;
        solta("wrap1", 4'd2);

        // Timeout with another requester pending
        req = 16'h0208;
        passo();
        confere_grant("tmo", 4'd3);
        for (int i = 1; i < 8; i++) begin
            passo();
            verifica("tmo_hold", 32'(grant_valido), 32'd1);
            verifica("tmo_nopulse", 32'(timeout_pulso), 32'd0);
        end
        passo();
        verifica("tmo_drop",  32'(grant_valido),  32'd0);
        verifica("tmo_pulse", 32'(timeout_pulso), 32'd1);
        verifica("tmo_ptr",   32'(dut.ponteiro),  32'd4);
        passo();
        confere_grant("tmo_next", 4'd9);
        verifica("tmo_pulse_end", 32'(timeout_pulso), 32'd0);
        req = '0;
        solta("tmo_next", 4'd10);

        // liberar coincident with timeout
        req = 16'h0008;
        passo();
        confere_grant("sim", 4'd3);
        for (int i = 1; i < 8; i++) passo();
        verifica("sim_hold", 32'(grant_valido), 32'd1);
        solta("sim", 4'd4);

        // Reset mid-grant
        req = 16'h0020;
        passo();
        confere_grant("rstmid", 4'd5);
        passo();
        rst = 1'b1;
        passo();
        rst = 1'b0;
        req = '0;
        verifica("rstmid_valido", 32'(grant_valido),  32'd0);
        verifica("rstmid_vetor",  32'(grant_vetor),   32'd0);
        verifica("rstmid_indice", 32'(grant_indice),  32'd0);
        verifica("rstmid_tmo",    32'(timeout_pulso), 32'd0);
        verifica("rstmid_ptr",    32'(dut.ponteiro),  32'd0);

        // Requester drop, with a non-granted toggle ignored
        req = 16'h0004;
        passo();
        confere_grant("drop", 4'd2);
        req = 16'h0006;
        passo();
        confere_grant("drop_tog1", 4'd2);
        req = 16'h0004;
        passo();
        confere_grant("drop_tog0", 4'd2);
        req = '0;
        passo();
        verifica("drop_valido", 32'(grant_valido),  32'd0);
        verifica("drop_tmo",    32'(timeout_pulso), 32'd0);
        verifica("drop_ptr",    32'(dut.ponteiro),  32'd3);
        passo();
        verifica("drop_idle", 32'(grant_valido), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
